// File: rtl/apb_master_nslave_if.sv
// Command/response port plus the fan-out APB bus of the multi-slave APB master bridge.
interface apb_master_nslave_if #(
   parameter int ADDR_W     = 8,
   parameter int DATA_W     = 8,
   parameter int NUM_SLAVES = 2,
   parameter int SEL_W      = 2
);
   logic                         cmd_valid;
   logic                         cmd_ready;
   logic                         cmd_write;
   logic [SEL_W+ADDR_W-1:0]      cmd_addr;
   logic [DATA_W-1:0]            cmd_wdata;
   logic                         rsp_valid;
   logic                         rsp_err;
   logic [DATA_W-1:0]            rsp_rdata;
   logic [NUM_SLAVES-1:0]        PSEL;
   logic                         PENABLE;
   logic                         PWRITE;
   logic [ADDR_W-1:0]            PADDR;
   logic [DATA_W-1:0]            PWDATA;
   logic [NUM_SLAVES*DATA_W-1:0] PRDATA;
   logic [NUM_SLAVES-1:0]        PREADY;
   logic [NUM_SLAVES-1:0]        PSLVERR;

   // Bridge side: drives command handshake, responses and the APB request signals.
   modport master (
      input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
      output cmd_ready,
      output rsp_valid, rsp_err, rsp_rdata,
      output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
      input  PRDATA, PREADY, PSLVERR
   );

   // Environment side: command source and the APB slaves.
   modport slave (
      output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
      input  cmd_ready,
      input  rsp_valid, rsp_err, rsp_rdata,
      input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
      output PRDATA, PREADY, PSLVERR
   );
endinterface

// File: rtl/apb_master_nslave.sv
// APB master bridge for NUM_SLAVES slaves: single commands in, SETUP/ACCESS transfers out,
// with slave-error forwarding, decode-error responses and a bounded wait-state timeout.
module apb_master_nslave #(
   parameter int ADDR_W     = 8,
   parameter int DATA_W     = 8,
   parameter int NUM_SLAVES = 2,
   parameter int SEL_W      = 2,
   parameter int TIMEOUT    = 15
) (
   input logic PCLK,
   input logic PRESET,
   apb_master_nslave_if.master bus
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      ACCESS
   } state_t;

   state_t              state_q, state_d;
   logic [SEL_W-1:0]    idx_q, idx_d;
   logic [ADDR_W-1:0]   paddr_q, paddr_d;
   logic [DATA_W-1:0]   pwdata_q, pwdata_d;
   logic                pwrite_q, pwrite_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                rsp_valid_q, rsp_valid_d;
   logic                rsp_err_q, rsp_err_d;
   logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;

   logic [SEL_W-1:0]      cmd_idx;
   logic                  decode_err;
   logic                  accept;
   logic [NUM_SLAVES-1:0] psel;
   logic                  pready_sel;
   logic                  pslverr_sel;
   logic [DATA_W-1:0]     prdata_sel;

   assign cmd_idx    = bus.cmd_addr[SEL_W+ADDR_W-1:ADDR_W];
   assign decode_err = int'(cmd_idx) >= NUM_SLAVES;
   assign accept     = bus.cmd_valid && (state_q == IDLE);

   // Pick out the addressed slave's return signals; a loop compare avoids an over-wide bit index.
   always_comb begin
      pready_sel  = 1'b0;
      pslverr_sel = 1'b0;
      prdata_sel  = '0;
      for (int i = 0; i < NUM_SLAVES; i++) begin
         if (idx_q == SEL_W'(i)) begin
            pready_sel  = bus.PREADY[i];
            pslverr_sel = bus.PSLVERR[i];
            prdata_sel  = bus.PRDATA[i*DATA_W +: DATA_W];
         end
      end
   end

   // One-hot select, only while a transfer is in SETUP or ACCESS.
   always_comb begin
      psel = '0;
      if (state_q != IDLE) begin
         for (int i = 0; i < NUM_SLAVES; i++) begin
            psel[i] = (idx_q == SEL_W'(i));
         end
      end
   end

   // Next-state logic: latch commands, sequence SETUP/ACCESS, count waits and build the response.
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      paddr_d     = paddr_q;
      pwdata_d    = pwdata_q;
      pwrite_d    = pwrite_q;
      cnt_d       = cnt_q;
      rsp_valid_d = 1'b0;
      rsp_err_d   = 1'b0;
      rsp_rdata_d = '0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               if (decode_err) begin
                  rsp_valid_d = 1'b1;
                  rsp_err_d   = 1'b1;
               end else begin
                  idx_d    = cmd_idx;
                  paddr_d  = bus.cmd_addr[ADDR_W-1:0];
                  pwdata_d = bus.cmd_wdata;
                  pwrite_d = bus.cmd_write;
                  state_d  = SETUP;
               end
            end
         end
         SETUP: begin
            cnt_d   = '0;
            state_d = ACCESS;
         end
         ACCESS: begin
            if (pready_sel) begin
               state_d     = IDLE;
               rsp_valid_d = 1'b1;
               rsp_err_d   = pslverr_sel;
               if (!pwrite_q && !pslverr_sel) begin
                  rsp_rdata_d = prdata_sel;
               end
            end else if (cnt_q == CNT_W'(TIMEOUT)) begin
               state_d     = IDLE;
               rsp_valid_d = 1'b1;
               rsp_err_d   = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and output registers; reset also discards any response for an in-flight command.
   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         state_q     <= IDLE;
         idx_q       <= '0;
         paddr_q     <= '0;
         pwdata_q    <= '0;
         pwrite_q    <= 1'b0;
         cnt_q       <= '0;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_rdata_q <= '0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         paddr_q     <= paddr_d;
         pwdata_q    <= pwdata_d;
         pwrite_q    <= pwrite_d;
         cnt_q       <= cnt_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_err_q   <= rsp_err_d;
         rsp_rdata_q <= rsp_rdata_d;
      end
   end

   assign bus.cmd_ready = (state_q == IDLE);
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_err   = rsp_err_q;
   assign bus.rsp_rdata = rsp_rdata_q;
   assign bus.PSEL      = psel;
   assign bus.PENABLE   = (state_q == ACCESS);
   assign bus.PWRITE    = pwrite_q;
   assign bus.PADDR     = paddr_q;
   assign bus.PWDATA    = pwdata_q;

endmodule
